// File: rtl/furv_mem.sv
// furv_mem: unified instruction/data memory for a small RISC-V core.
// A boot loader streams the program in while in LOAD; once the last word
// lands the block switches to RUN and serves instruction fetches and
// data loads/stores. A store to TOHOST_ADDR is captured into a host-output
// register and flagged with a one-cycle pulse.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   pc, instruction     fetch address and combinational instruction word
//   addr, data          data byte address and shared bidirectional data bus
//   mem, mem_read       data access strobe and direction (1 = load)
//   load_valid/data/last, load_ready   boot-load word stream
//   core_run            program loaded, core may execute
//   tohost_data/valid   host-output register and its per-store pulse
module furv_mem #(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter logic [31:0] TOHOST_ADDR = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] instruction,
  input  logic [31:0] addr,
  inout  wire  [31:0] data,
  input  logic        mem,
  input  logic        mem_read,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        core_run,
  output logic [31:0] tohost_data,
  output logic        tohost_valid
);

  localparam int unsigned Words = 2 ** DEPTH_LOG2;
  localparam logic [31:0] Nop   = 32'h0000_0013;

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [DEPTH_LOG2-1:0] load_ptr_q, load_ptr_d;
  logic [31:0]           tohost_data_q;
  logic                  tohost_valid_q;
  logic [31:0]           ram [Words];

  logic                  run;
  logic                  pc_in_range, addr_in_range, tohost_hit;
  logic [DEPTH_LOG2-1:0] pc_idx, addr_idx;
  logic                  load_accept, store_en, read_en;
  logic [31:0]           rd_val;

  // Sub-word address bits are not used: all accesses are full words.
  logic unused_low_bits;
  assign unused_low_bits = ^{pc[1:0], addr[1:0]};

  assign run           = (state_q == ST_RUN);
  assign pc_idx        = pc[DEPTH_LOG2+1:2];
  assign addr_idx      = addr[DEPTH_LOG2+1:2];
  assign pc_in_range   = (pc[31:DEPTH_LOG2+2] == '0);
  assign addr_in_range = (addr[31:DEPTH_LOG2+2] == '0);
  assign tohost_hit    = (addr == TOHOST_ADDR);

  assign load_accept = !run && load_valid;
  assign store_en    = run && mem && !mem_read;
  assign read_en     = run && mem && mem_read;

  // Next state: leave LOAD on the explicit last word or when the final slot
  // is filled, so load_ptr never wraps back over word 0.
  always_comb begin
    state_d    = state_q;
    load_ptr_d = load_ptr_q;
    if (load_accept) begin
      load_ptr_d = load_ptr_q + 1'b1;
      if (load_last || (&load_ptr_q)) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_LOAD;
      load_ptr_q     <= '0;
      tohost_data_q  <= '0;
      tohost_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      load_ptr_q     <= load_ptr_d;
      tohost_valid_q <= store_en && tohost_hit;
      if (store_en && tohost_hit) begin
        tohost_data_q <= data;
      end
    end
  end

  // Array is deliberately outside the reset so a reload only rewrites what
  // it streams in; reset still blocks a write on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load_accept) begin
        ram[load_ptr_q] <= load_data;
      end else if (store_en && addr_in_range) begin
        ram[addr_idx] <= data;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (addr_in_range) begin
      rd_val = ram[addr_idx];
    end else if (tohost_hit) begin
      rd_val = tohost_data_q;
    end
  end

  assign data         = read_en ? rd_val : 'z;
  assign instruction  = (run && pc_in_range) ? ram[pc_idx] : Nop;
  assign load_ready   = !run;
  assign core_run     = run;
  assign tohost_data  = tohost_data_q;
  assign tohost_valid = tohost_valid_q;

endmodule

// File: tb/tb_furv_mem.sv
module tb_furv_mem;

  localparam int unsigned  DL2    = 8;
  localparam int unsigned  WORDS  = 2 ** DL2;
  localparam logic [31:0]  TOHOST = 32'hFFFF_FFF0;
  localparam logic [31:0]  NOP    = 32'h0000_0013;
  localparam logic [31:0]  PAT    = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, addr, load_data, tb_data;
  logic        mem, mem_read, load_valid, load_last, tb_drive;
  logic [31:0] instruction, tohost_data;
  logic        load_ready, core_run, tohost_valid;
  wire  [31:0] data;

  assign data = tb_drive ? tb_data : 'z;

  furv_mem #(
    .DEPTH_LOG2  (DL2),
    .TOHOST_ADDR (TOHOST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .instruction  (instruction),
    .addr         (addr),
    .data         (data),
    .mem          (mem),
    .mem_read     (mem_read),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .core_run     (core_run),
    .tohost_data  (tohost_data),
    .tohost_valid (tohost_valid)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [WORDS];
  logic [31:0] exp_q [$];
  int          ptr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    mem        = 1'b0;
    mem_read   = 1'b1;
    load_valid = 1'b0;
    load_last  = 1'b0;
    tb_drive   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    ptr = 0;
  endtask

  task automatic load_word(input logic [31:0] w, input logic last);
    load_valid = 1'b1;
    load_data  = w;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    model[ptr] = w;
    ptr++;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem      = 1'b1;
    mem_read = 1'b0;
    addr     = a;
    tb_data  = d;
    tb_drive = 1'b1;
    tick();
    idle();
    if (a[31:DL2+2] == '0) model[a[DL2+1:2]] = d;
  endtask

  // Expected value queued when the read is issued, compared when the bus settles.
  task automatic read_bus(input string tag, input logic [31:0] a, input logic [31:0] exp);
    mem      = 1'b1;
    mem_read = 1'b1;
    addr     = a;
    exp_q.push_back(exp);
    settle();
    check_eq(tag, data, exp_q.pop_front());
    tick();
    idle();
  endtask

  task automatic fetch(input string tag, input logic [31:0] p, input logic [31:0] exp);
    pc = p;
    settle();
    check_eq(tag, instruction, exp);
  endtask

  // While idle in LOAD the bench drives a pattern; any DUT drive corrupts it.
  task automatic check_no_drive(input string tag, input logic [31:0] a);
    mem      = 1'b1;
    mem_read = 1'b1;
    addr     = a;
    tb_data  = PAT;
    tb_drive = 1'b1;
    settle();
    check_eq(tag, data, PAT);
    tick();
    idle();
  endtask

  initial begin
    pc = '0; addr = '0; load_data = '0; tb_data = '0;
    do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check_eq("rst_load_ready", {31'b0, load_ready}, 32'd1);
    check_eq("rst_core_run", {31'b0, core_run}, 32'd0);
    check_eq("rst_tohost_valid", {31'b0, tohost_valid}, 32'd0);
    check_eq("rst_tohost_data", tohost_data, 32'd0);
    fetch("preload_nop", 32'h0, NOP);
    check_no_drive("preload_hiz", 32'h0);

    // Three-word program, last flag on the third word.
    load_word(32'h11, 1'b0);
    load_word(32'h22, 1'b0);
    settle();
    check_eq("mid_load_ready", {31'b0, load_ready}, 32'd1);
    load_word(32'h33, 1'b1);
    settle();
    check_eq("run_load_ready", {31'b0, load_ready}, 32'd0);
    check_eq("run_core_run", {31'b0, core_run}, 32'd1);
    fetch("fetch_pc8", 32'h8, 32'h33);
    fetch("fetch_pc4", 32'h4, 32'h22);
    fetch("fetch_oob", 32'h400, NOP);

    // Store then read back with ignored byte-offset bits.
    store(32'h40, 32'hDEAD_BEEF);
    read_bus("rd_0x43", 32'h43, model[16]);

    // Fetch of a word being stored shows old contents until the edge.
    pc = 32'h40;
    mem = 1'b1; mem_read = 1'b0; addr = 32'h40; tb_data = 32'h1234_5678; tb_drive = 1'b1;
    settle();
    check_eq("rdw_old", instruction, 32'hDEAD_BEEF);
    tick();
    idle();
    model[16] = 32'h1234_5678;
    fetch("rdw_new", 32'h40, model[16]);

    // Host-output register.
    store(TOHOST, 32'h1);
    settle();
    check_eq("tohost_pulse", {31'b0, tohost_valid}, 32'd1);
    check_eq("tohost_data1", tohost_data, 32'h1);
    tick();
    check_eq("tohost_drop", {31'b0, tohost_valid}, 32'd0);
    read_bus("rd_tohost", TOHOST, 32'h1);
    store(TOHOST, 32'h5);
    settle();
    check_eq("b2b_pulse1", {31'b0, tohost_valid}, 32'd1);
    store(TOHOST, 32'h6);
    settle();
    check_eq("b2b_pulse2", {31'b0, tohost_valid}, 32'd1);
    check_eq("b2b_data2", tohost_data, 32'h6);
    tick();
    check_eq("b2b_drop", {31'b0, tohost_valid}, 32'd0);

    // Out-of-range, non-tohost store is dropped.
    store(32'h400, 32'hCAFE_F00D);
    fetch("oob_store_w0", 32'h0, 32'h11);
    read_bus("rd_oob", 32'h400, 32'h0);

    // Reset keeps the array; LOAD ignores the data bus.
    do_reset();
    settle();
    check_eq("rst2_load_ready", {31'b0, load_ready}, 32'd1);
    check_eq("rst2_tohost_data", tohost_data, 32'd0);
    check_no_drive("load_hiz", 32'h0);
    mem = 1'b1; mem_read = 1'b0; addr = 32'h40; tb_data = 32'h99; tb_drive = 1'b1;
    tick();
    idle();

    // Abort a load after two of four words; restart lands at word 0.
    load_word(32'hA0, 1'b0);
    load_word(32'hA1, 1'b0);
    do_reset();
    settle();
    check_eq("abort_load_ready", {31'b0, load_ready}, 32'd1);
    load_word(32'hB0, 1'b1);
    settle();
    check_eq("abort_core_run", {31'b0, core_run}, 32'd1);
    fetch("abort_w0", 32'h0, 32'hB0);
    fetch("abort_w1", 32'h4, 32'hA1);
    fetch("keep_w16", 32'h40, 32'h1234_5678);
    fetch("keep_w2", 32'h8, 32'h33);

    // Fill every slot without a last flag.
    do_reset();
    for (int i = 0; i < WORDS - 1; i++) load_word(32'h1000 + i, 1'b0);
    settle();
    check_eq("full_pre_ready", {31'b0, load_ready}, 32'd1);
    load_word(32'h1000 + WORDS - 1, 1'b0);
    settle();
    check_eq("full_core_run", {31'b0, core_run}, 32'd1);
    load_word(32'h0BAD, 1'b1);
    fetch("full_w0", 32'h0, 32'h1000);
    fetch("full_w255", 32'h3FC, 32'h10FF);
    store(32'h400, 32'hCAFE_F00D);
    fetch("full_oob_w0", 32'h0, 32'h1000);
    read_bus("full_rd_oob", 32'h400, 32'h0);
    read_bus("full_rd_w255", 32'h3FC, model[255]);
    read_bus("full_rd_tohost", TOHOST, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/furv_mem.md
FURV_MEM -- requirements
Module: furv_mem

Interface
REQ-001 Parameter DEPTH_LOG2, default 8; memory holds 2**DEPTH_LOG2 32-bit words.
REQ-002 Parameter TOHOST_ADDR, default 32'hFFFF_FFF0; byte address of the memory-mapped host-output register.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port pc  input  32  core program counter (byte address).
REQ-006 Port instruction  output  32  instruction word fetched at pc.
REQ-007 Port addr  input  32  core data byte address.
REQ-008 Port data  inout  32  bidirectional data bus shared with the core.
REQ-009 Port mem  input  1  core data access active.
REQ-010 Port mem_read  input  1  1 = load, 0 = store; meaningful only when mem=1.
REQ-011 Port load_valid  input  1  boot-load word present.
REQ-012 Port load_data  input  32  boot-load word.
REQ-013 Port load_last  input  1  current boot-load word is the final one.
REQ-014 Port load_ready  output  1  block accepts boot-load words.
REQ-015 Port core_run  output  1  1 = program loaded, core may execute.
REQ-016 Port tohost_data  output  32  last value stored to TOHOST_ADDR.
REQ-017 Port tohost_valid  output  1  one-cycle pulse per store to TOHOST_ADDR.

Function
REQ-018 The block SHALL implement two states, LOAD and RUN; load_ready=1 exactly in LOAD, core_run=1 exactly in RUN.
REQ-019 Word index SHALL be address bits [DEPTH_LOG2+1:2]; bits [1:0] ignored (no byte/halfword access).
REQ-020 An address is in-range when bits [31:DEPTH_LOG2+2] are all zero.
REQ-021 LOAD: on a rising edge with load_valid=1, the block SHALL write load_data to word load_ptr and increment load_ptr (DEPTH_LOG2 bits).
REQ-022 LOAD -> RUN on the edge accepting a word with load_last=1, or accepting the word at load_ptr=2**DEPTH_LOG2-1; load_ptr never wraps into reuse.
REQ-023 RUN: load_valid, load_data, load_last SHALL be ignored; only rst returns to LOAD.
REQ-024 instruction SHALL be combinational: mem[pc index] when pc in-range and state=RUN; else 32'h0000_0013 (NOP).
REQ-025 data SHALL be driven only when state=RUN, mem=1, mem_read=1; else high-impedance.
REQ-026 Driven read value, combinational from addr: word contents if in-range; tohost_data if addr==TOHOST_ADDR; else 32'h0.
REQ-027 Store: on a rising edge with state=RUN, mem=1, mem_read=0, the block SHALL write data to the addressed word if in-range.
REQ-028 Store to TOHOST_ADDR SHALL load tohost_data with data and assert tohost_valid for exactly the following cycle; back-to-back stores yield back-to-back pulses.
REQ-029 Stores to other out-of-range addresses SHALL be ignored without side effect.
REQ-030 Stores and loads while state=LOAD SHALL be ignored; data stays high-impedance.
REQ-031 Read-during-write to the same word SHALL return the old contents (write takes effect after the edge).
REQ-032 Memory SHALL start in the RUN state is forbidden: no path reaches RUN except REQ-022.

Reset
REQ-033 On a rising edge with rst=1: state=LOAD, load_ptr=0, tohost_data=0, tohost_valid=0; rst overrides a simultaneous load or store.
REQ-034 Memory array contents SHALL NOT be cleared by rst; a subsequent load overwrites from word 0.
REQ-035 rst asserted mid-load SHALL discard progress; the next load restarts at word 0.

Verification
REQ-036 Reset, load 3 words 0x11,0x22,0x33 (last on third) -> load_ready falls, core_run rises next cycle; pc=8 gives instruction 0x33.
REQ-037 Before load completes, pc=0 -> instruction 0x00000013, mem=1 mem_read=1 -> data high-Z, load_ready=1.
REQ-038 RUN, store 0xDEADBEEF to addr 0x40, then load addr 0x43 -> data reads 0xDEADBEEF.
REQ-039 RUN, store 0x1 to 0xFFFF_FFF0 -> tohost_valid high exactly one cycle, tohost_data=0x1; load of 0xFFFF_FFF0 returns 0x1.
REQ-040 Load 256 words without load_last (DEPTH_LOG2=8) -> RUN after word 255; extra load_valid ignored; load of addr 0x400 returns 0, store there leaves word 0 unchanged.
REQ-041 rst pulsed after 2 of 4 load words -> state LOAD, load_ptr=0; next accepted word lands at word 0.
